cp0_intc: RTL and testbench

CP0_INTC -- requirements
Module: cp0_intc

---
 rtl/cp0_intc_pkg.sv | 15 +
 rtl/cp0_intc_sync.sv | 34 +++
 rtl/cp0_intc.sv | 152 +++++++++++++++
 tb/tb_cp0_intc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_intc_pkg.sv
// Shared constants for the CP0 interrupt controller: register indices and
// CTRL bit positions.
package cp0_intc_pkg;

  localparam logic [2:0] REG_COUNT        = 3'd0;
  localparam logic [2:0] REG_CTRL         = 3'd1;
  localparam logic [2:0] REG_PENDING      = 3'd2;
  localparam logic [2:0] REG_MASK         = 3'd3;
  localparam logic [2:0] REG_COMPARE_BASE = 3'd4;

  localparam int CTRL_COUNT_EN_BIT = 0;

  localparam int IP_W = 16;

endpackage

// File: rtl/cp0_intc_sync.sv
// Synchronizer chain for one asynchronous interrupt line, plus a rising-edge
// detect on the synchronized value.
module cp0_intc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cp0_intc.sv
// CP0-style interrupt controller: Count/Compare timer channels, synchronized
// hardware lines with level/edge pending logic, masking and priority encode.
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter int N_HWINT     = 6,
  parameter int N_CMP       = 2,
  parameter int CNT_W       = 32,
  parameter int DIV         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic [N_HWINT-1:0] edge_mode,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [2:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic               ie,
  input  logic               exl,
  input  logic               erl,
  input  logic               int_ack,
  output logic               int_req,
  output logic [3:0]         int_vec,
  output logic [15:0]        ip
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  logic [CNT_W-1:0]   count_q, count_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               count_en_q, count_en_d;
  logic [CNT_W-1:0]   cmp_q [N_CMP];
  logic [CNT_W-1:0]   cmp_d [N_CMP];
  logic [IP_W-1:0]    mask_q, mask_d;
  logic [N_CMP-1:0]   ti_q, ti_d;
  logic [N_HWINT-1:0] hwp_q, hwp_d;
  logic               int_req_q, int_req_d;

  logic [N_HWINT-1:0] hw_sync, hw_rise;
  logic [N_CMP-1:0]   wr_cmp;
  logic               wr_count, wr_ctrl, wr_pend, wr_mask;
  logic               tick, ack_fire, clr;
  logic [IP_W-1:0]    pend, masked;
  logic [3:0]         vec;

  for (genvar g = 0; g < N_HWINT; g++) begin : gen_sync
    cp0_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .async_i(hw_int[g]),
      .sync_o (hw_sync[g]),
      .rise_o (hw_rise[g])
    );
  end

  always_comb begin
    wr_count = wr_en && (wr_addr == REG_COUNT);
    wr_ctrl  = wr_en && (wr_addr == REG_CTRL);
    wr_pend  = wr_en && (wr_addr == REG_PENDING);
    wr_mask  = wr_en && (wr_addr == REG_MASK);
    for (int k = 0; k < N_CMP; k++) begin
      wr_cmp[k] = wr_en && (wr_addr == REG_COMPARE_BASE + 3'(k));
    end
  end

  // Pending vector: hardware lines at the bottom, timer channels above them.
  always_comb begin
    pend = '0;
    pend[N_HWINT-1:0]    = hwp_q;
    pend[N_HWINT +: N_CMP] = ti_q;
    masked = pend & mask_q;
    vec = '0;
    for (int i = 0; i < IP_W; i++) begin
      if (masked[i]) vec = 4'(i);
    end
  end

  always_comb begin
    tick       = count_en_q && (tick_q == TICK_MAX);
    tick_d     = tick_q;
    if (count_en_q) tick_d = tick ? '0 : tick_q + TW'(1);
    count_d    = count_q;
    if (wr_count)  count_d = wr_data[CNT_W-1:0];
    else if (tick) count_d = count_q + CNT_W'(1);
    count_en_d = wr_ctrl ? wr_data[CTRL_COUNT_EN_BIT] : count_en_q;
    mask_d     = wr_mask ? wr_data[IP_W-1:0] : mask_q;
    // A Compare write re-arms its channel and beats a same-cycle match.
    for (int k = 0; k < N_CMP; k++) begin
      cmp_d[k] = wr_cmp[k] ? wr_data[CNT_W-1:0] : cmp_q[k];
      ti_d[k]  = wr_cmp[k] ? 1'b0
                           : (ti_q[k] | (count_en_q && (count_q == cmp_q[k])));
    end
  end

  always_comb begin
    ack_fire = int_ack && int_req_q;
    clr      = 1'b0;
    hwp_d    = hwp_q;
    for (int i = 0; i < N_HWINT; i++) begin
      clr = (wr_pend && wr_data[i]) || (ack_fire && (vec == 4'(i)));
      if (edge_mode[i]) hwp_d[i] = hw_rise[i] | (hwp_q[i] & ~clr);
      else              hwp_d[i] = hw_sync[i];
    end
    int_req_d = (|masked) && ie && !exl && !erl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      tick_q     <= '0;
      count_en_q <= 1'b1;
      mask_q     <= '0;
      ti_q       <= '0;
      hwp_q      <= '0;
      int_req_q  <= 1'b0;
      for (int k = 0; k < N_CMP; k++) cmp_q[k] <= '1;
    end else begin
      count_q    <= count_d;
      tick_q     <= tick_d;
      count_en_q <= count_en_d;
      mask_q     <= mask_d;
      ti_q       <= ti_d;
      hwp_q      <= hwp_d;
      int_req_q  <= int_req_d;
      for (int k = 0; k < N_CMP; k++) cmp_q[k] <= cmp_d[k];
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_COUNT:   rd_data = 32'(count_q);
      REG_CTRL:    rd_data[CTRL_COUNT_EN_BIT] = count_en_q;
      REG_PENDING: rd_data = 32'(pend);
      REG_MASK:    rd_data = 32'(mask_q);
      default: begin
        for (int k = 0; k < N_CMP; k++) begin
          if (rd_addr == REG_COMPARE_BASE + 3'(k)) rd_data = 32'(cmp_q[k]);
        end
      end
    endcase
  end

  assign int_req = int_req_q;
  assign int_vec = vec;
  assign ip      = pend;

endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: directed scenarios plus random traffic, every cycle
// checked against a behavioural model through an expected-value queue.
module tb_cp0_intc;

  localparam int N_HWINT = 6, N_CMP = 2, CNT_W = 32, DIV = 2, SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_HWINT-1:0] hw_int, edge_mode;
  logic               wr_en;
  logic [2:0]         wr_addr, rd_addr;
  logic [31:0]        wr_data, rd_data;
  logic               ie, exl, erl, int_ack, int_req;
  logic [3:0]         int_vec;
  logic [15:0]        ip;

  always #5 clk = ~clk;

  cp0_intc #(
    .N_HWINT(N_HWINT), .N_CMP(N_CMP), .CNT_W(CNT_W), .DIV(DIV), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .edge_mode(edge_mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .ie(ie), .exl(exl), .erl(erl), .int_ack(int_ack),
    .int_req(int_req), .int_vec(int_vec), .ip(ip)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [52:0] exp_q[$];
  logic [52:0] mon_e;

  // Reference model state: architectural values after the most recent edge.
  logic [31:0]        m_count;
  int                 m_tick;
  logic               m_en;
  logic [31:0]        m_cmp [N_CMP];
  logic [15:0]        m_mask;
  logic [N_CMP-1:0]   m_ti;
  logic [N_HWINT-1:0] m_hwp;
  logic               m_req;
  logic [N_HWINT-1:0] m_hist [SYNC_STAGES+1];  // hw_int samples, [0] newest

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] m_ip();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < N_HWINT; i++) r[i] = m_hwp[i];
    for (int k = 0; k < N_CMP; k++) r[N_HWINT+k] = m_ti[k];
    return r;
  endfunction

  function automatic logic [3:0] m_vec(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    int ai;
    ai = int'(a);
    case (ai)
      0: return m_count;
      1: return {31'b0, m_en};
      2: return {16'b0, m_ip()};
      3: return {16'b0, m_mask};
      default: if (ai - 4 < N_CMP) return m_cmp[ai-4];
    endcase
    return 32'd0;
  endfunction

  task automatic model_edge();
    logic [15:0] masked;
    logic [3:0]  vec;
    logic        tick, ack_fire, sync, prev, clr;
    if (reset) begin
      m_count = 0; m_tick = 0; m_en = 1'b1; m_mask = 0; m_ti = 0; m_hwp = 0; m_req = 0;
      for (int k = 0; k < N_CMP; k++) m_cmp[k] = '1;
      for (int j = 0; j <= SYNC_STAGES; j++) m_hist[j] = '0;
    end else begin
      masked   = m_ip() & m_mask;
      vec      = m_vec(masked);
      tick     = m_en && (m_tick == DIV - 1);
      ack_fire = int_ack && m_req;
      for (int i = 0; i < N_HWINT; i++) begin
        sync = m_hist[SYNC_STAGES-1][i];
        prev = m_hist[SYNC_STAGES][i];
        if (edge_mode[i]) begin
          clr = (wr_en && wr_addr == 3'd2 && wr_data[i]) || (ack_fire && int'(vec) == i);
          if (sync && !prev) m_hwp[i] = 1'b1;
          else if (clr)      m_hwp[i] = 1'b0;
        end else begin
          m_hwp[i] = sync;
        end
      end
      for (int k = 0; k < N_CMP; k++) begin
        if (wr_en && int'(wr_addr) == 4 + k) begin
          m_ti[k]  = 1'b0;
          m_cmp[k] = wr_data;
        end else if (m_en && m_count == m_cmp[k]) begin
          m_ti[k] = 1'b1;
        end
      end
      if (wr_en && wr_addr == 3'd0) m_count = wr_data;
      else if (tick)                m_count = m_count + 32'd1;
      if (m_en) m_tick = tick ? 0 : m_tick + 1;
      m_req = (masked != 0) && ie && !exl && !erl;
      if (wr_en && wr_addr == 3'd1) m_en = wr_data[0];
      if (wr_en && wr_addr == 3'd3) m_mask = wr_data[15:0];
      for (int j = SYNC_STAGES; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = hw_int;
    end
  endtask

  // Apply the current inputs across one clock edge, queueing what the DUT must show after it.
  task automatic step();
    logic [15:0] ipn;
    model_edge();
    ipn = m_ip();
    exp_q.push_back({m_read(rd_addr), ipn, m_req, m_vec(ipn & m_mask)});
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 32'd1, 32'd0);
    end else begin
      mon_e = exp_q.pop_front();
      check("rd_data", rd_data, mon_e[52:21]);
      check("ip", 32'(ip), 32'(mon_e[20:5]));
      check("int_req", 32'(int_req), 32'(mon_e[4]));
      check("int_vec", 32'(int_vec), 32'(mon_e[3:0]));
    end
  end

  initial begin
    #1_000_000;
    check("timeout", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int sel;
    reset = 1'b1; hw_int = '0; edge_mode = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = 3'd0; ie = 1'b0; exl = 1'b0; erl = 1'b0; int_ack = 1'b0;
    step(); step();
    check("rst_count", rd_data, 32'd0);
    check("rst_ip", 32'(ip), 32'd0);
    check("rst_req", 32'(int_req), 32'd0);
    check("rst_vec", 32'(int_vec), 32'd0);

    // Compare channel 0 at 10 with DIV=2: flag rises on edge 21 after release.
    reset = 1'b0;
    write(3'd4, 32'd10);
    for (int j = 2; j <= 20; j++) step();
    check("ti0_early", 32'(ip[6]), 32'd0);
    step();
    check("ti0_rise", 32'(ip[6]), 32'd1);
    check("count_at_21", rd_data, 32'd10);
    write(3'd4, 32'd10);
    check("ti0_wr_clear", 32'(ip[6]), 32'd0);

    // Edge line 2: latency, request, acknowledge.
    reset = 1'b1; step(); reset = 1'b0;
    edge_mode = 6'b000100; ie = 1'b1;
    write(3'd3, 32'h0004);
    hw_int[2] = 1'b1; step();
    hw_int[2] = 1'b0; step();
    check("edge_not_early", 32'(ip[2]), 32'd0);
    step();
    check("edge_latency", 32'(ip[2]), 32'd1);
    check("req_not_yet", 32'(int_req), 32'd0);
    step();
    check("req_set", 32'(int_req), 32'd1);
    check("vec_2", 32'(int_vec), 32'd2);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("ack_clear", 32'(ip[2]), 32'd0);
    step();
    check("req_drop", 32'(int_req), 32'd0);

    // New edge beats a same-cycle PENDING write-1-clear.
    hw_int[2] = 1'b1; step();
    hw_int[2] = 1'b0; step(); step();
    hw_int[2] = 1'b1; step();
    hw_int[2] = 1'b0; step();
    write(3'd2, 32'h4);
    check("edge_beats_clr", 32'(ip[2]), 32'd1);
    write(3'd2, 32'h4);
    check("pend_w1c", 32'(ip[2]), 32'd0);

    // Level line 1 and timer line 7 together.
    write(3'd3, 32'hFFFF);
    hw_int[1] = 1'b1;
    write(3'd5, 32'd50);
    write(3'd0, 32'd50);
    repeat (4) step();
    check("lvl_tmr_ip", 32'(ip), 32'h0082);
    check("vec_7", 32'(int_vec), 32'd7);
    check("req_lvl_tmr", 32'(int_req), 32'd1);
    write(3'd2, 32'hFFFF_FFFF);
    check("lvl_ignores_clr", 32'(ip), 32'h0082);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tmr_ignores_ack", 32'(ip), 32'h0082);
    exl = 1'b1; step();
    check("exl_gate", 32'(int_req), 32'd0);
    check("exl_ip_hold", 32'(ip), 32'h0082);
    exl = 1'b0; hw_int[1] = 1'b0;

    // Wrap: COUNT all ones ticks to 0 and fires Compare[1]=0.
    reset = 1'b1; step(); reset = 1'b0;
    write(3'd5, 32'd0);
    write(3'd0, 32'hFFFF_FFFF);
    repeat (4) step();
    check("wrap_count", rd_data, 32'd1);
    check("wrap_ti1", 32'(ip[7]), 32'd1);

    // Mid-operation reset overrides a same-cycle write and edge.
    reset = 1'b1; step(); reset = 1'b0;
    edge_mode = 6'b000100;
    write(3'd4, 32'd500);
    write(3'd3, 32'h0044);
    write(3'd0, 32'd500);
    hw_int[2] = 1'b1; step();
    hw_int[2] = 1'b0; step(); step(); step();
    check("pre_rst_ip", 32'(ip), 32'h0044);
    check("pre_rst_req", 32'(int_req), 32'd1);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd123; hw_int[2] = 1'b1; rd_addr = 3'd0;
    step();
    check("rst_mid_count", rd_data, 32'd0);
    check("rst_mid_ip", 32'(ip), 32'd0);
    check("rst_mid_req", 32'(int_req), 32'd0);
    wr_addr = 3'd4; wr_data = 32'd7; rd_addr = 3'd4; step();
    check("rst_cmp0", rd_data, 32'hFFFF_FFFF);
    rd_addr = 3'd5; step();
    check("rst_cmp1", rd_data, 32'hFFFF_FFFF);
    reset = 1'b0; wr_en = 1'b0; hw_int = '0;

    // Random traffic against the model.
    edge_mode = 6'b101100;
    for (int c = 0; c < 2000; c++) begin
      reset   = ($urandom_range(0, 399) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      case (wr_addr)
        3'd0: begin
          sel = int'($urandom_range(0, 2));
          if (sel == 0)      wr_data = $urandom;
          else if (sel == 1) wr_data = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          else               wr_data = m_count + 32'($urandom_range(0, 4));
        end
        3'd1: begin
          wr_data    = $urandom;
          wr_data[0] = ($urandom_range(0, 4) != 0);
        end
        3'd4, 3'd5: wr_data = m_count + 32'($urandom_range(0, 8));
        default:    wr_data = $urandom;
      endcase
      for (int i = 0; i < N_HWINT; i++) if ($urandom_range(0, 5) == 0) hw_int[i] = ~hw_int[i];
      if ($urandom_range(0, 99) == 0) edge_mode = 6'($urandom_range(0, 63));
      ie      = ($urandom_range(0, 7) != 0);
      exl     = ($urandom_range(0, 9) == 0);
      erl     = ($urandom_range(0, 19) == 0);
      int_ack = ($urandom_range(0, 2) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
